// File: rtl/sseg_mux_bcd.sv
// Binary-to-BCD (double dabble) converter feeding a scanned, active-low 7-segment display.
// Optional leading-zero blanking is enabled by defining SSEG_LEADING_ZERO_BLANK_EN.
module sseg_mux_bcd #(
  parameter int NDIGITS     = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BIN_W-1:0]   bin,
  input  logic               load,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic [NDIGITS-1:0] an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int BCD_W = 4 * NDIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int k = 0; k < n; k++) r = r * 32'd10;
    return r;
  endfunction

  localparam logic [31:0] MAX_VAL = pow10(NDIGITS) - 32'd1;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   sh_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;
  logic [BCD_W-1:0]   disp_q;
  logic               ovf_q;
  logic               done_q;
  logic [REF_W-1:0]   ref_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NDIGITS-1:0] an_q;
  logic [6:0]         seg_q, seg_d;

  // Double-dabble step: correct every nibble >= 5, then shift {bcd, bin} left by one.
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shl;
  logic [BIN_W-1:0] sh_shl;
  logic             shift_carry;

  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                            : bcd_q[4*gi +: 4];
  end

  assign {shift_carry, bcd_shl, sh_shl} = {bcd_adj, sh_q, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(BIN_W - 1)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            sh_q       <= bin;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (32'(bin) > MAX_VAL);
          end
        end
        SHIFT: begin
          sh_q  <= sh_shl;
          bcd_q <= bcd_shl;
          cnt_q <= cnt_q + CNT_W'(1);
          if (shift_carry) ovf_pend_q <= 1'b1;
        end
        UPDATE: begin
          disp_q <= bcd_q;
          ovf_q  <= ovf_pend_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [3:0] nib;
  assign nib = disp_q[{idx_q, 2'b00} +: 4];

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero; digit 0 is never blanked.
  logic [NDIGITS-1:0] blank;
  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_lsd
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign blank[gi] = (disp_q[BCD_W-1:4*gi] == '0);
    end
  end
`endif

  always_comb begin
    seg_d = dec7(nib);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if (blank[idx_q]) seg_d = 7'b1111111;
`endif
    if (ovf_q) seg_d = 7'b0111111;
  end

  // Scanning runs free of the converter; an and seg share one register stage so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= 7'b1111111;
    end else begin
      an_q  <= ~(NDIGITS'(1) << idx_q);
      seg_q <= seg_d;
      if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
        ref_q <= '0;
        idx_q <= (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        ref_q <= ref_q + REF_W'(1);
      end
    end
  end

  assign done = done_q;
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;

endmodule
